padding_addr_gen: RTL and testbench

PADDING_ADDR_GEN -- requirements
Module: padding_addr_gen

---
 rtl/padding_pkg.sv | 14 +
 rtl/padding_pixel_map.sv | 50 +++++
 rtl/padding_addr_gen.sv | 191 +++++++++++++++++++
 tb/tb_padding_addr_gen.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/padding_pkg.sv
// rtl/padding_pkg.sv - shared encodings and FSM states for the padding address generator
package padding_pkg;

  localparam logic [1:0] EN_NONE = 2'd0;
  localparam logic [1:0] EN_PAD  = 2'd1;
  localparam logic [1:0] EN_FM   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/padding_pixel_map.sv
// rtl/padding_pixel_map.sv - maps a padded coordinate to a feature-map address or a padding marker
module padding_pixel_map
  import padding_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int COORD_W = 11,
  parameter int PAD_W   = 4,
  parameter int CH_W    = 8
) (
  input  logic [CH_W-1:0]    ch,
  input  logic [COORD_W:0]   py,
  input  logic [COORD_W:0]   px,
  input  logic [ADDR_W-1:0]  base,
  input  logic [COORD_W-1:0] fm_x,
  input  logic [COORD_W-1:0] fm_y,
  input  logic [PAD_W-1:0]   pad_up,
  input  logic [PAD_W-1:0]   pad_left,
  output logic [ADDR_W-1:0]  addr,
  output logic [1:0]         en
);

  logic [COORD_W:0]  up_w;
  logic [COORD_W:0]  left_w;
  logic [COORD_W:0]  row;
  logic [COORD_W:0]  col;
  logic              in_x;
  logic              in_y;
  logic [ADDR_W-1:0] plane_row;

  assign up_w   = (COORD_W+1)'(pad_up);
  assign left_w = (COORD_W+1)'(pad_left);

  // One extra bit on the bounds keeps pad + size from wrapping.
  assign in_x = (px >= left_w) && (px < left_w + {1'b0, fm_x});
  assign in_y = (py >= up_w)   && (py < up_w + {1'b0, fm_y});

  assign row       = py - up_w;
  assign col       = px - left_w;
  assign plane_row = ADDR_W'(ch) * ADDR_W'(fm_y) + ADDR_W'(row);

  always_comb begin
    addr = '0;
    en   = EN_PAD;
    if (in_x && in_y) begin
      addr = base + plane_row * ADDR_W'(fm_x) + ADDR_W'(col);
      en   = EN_FM;
    end
  end

endmodule

// File: rtl/padding_addr_gen.sv
// rtl/padding_addr_gen.sv - sweeps a padded feature map and streams one element address per beat
module padding_addr_gen
  import padding_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int COORD_W = 11,
  parameter int PAD_W   = 4,
  parameter int CH_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  baseAddr,
  input  logic [COORD_W-1:0] fmX,
  input  logic [COORD_W-1:0] fmY,
  input  logic [CH_W-1:0]    fmCh,
  input  logic [PAD_W-1:0]   paddingUp,
  input  logic [PAD_W-1:0]   paddingDown,
  input  logic [PAD_W-1:0]   paddingLeft,
  input  logic [PAD_W-1:0]   paddingRight,
  input  logic               outReady,
  output logic               outValid,
  output logic [ADDR_W-1:0]  realAddr,
  output logic [1:0]         realAddrEn,
  output logic               busy,
  output logic               done
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0]  base_q;
  logic [COORD_W-1:0] fm_x_q, fm_y_q;
  logic [CH_W-1:0]    fm_ch_q;
  logic [PAD_W-1:0]   pad_u_q, pad_d_q, pad_l_q, pad_r_q;

  logic [CH_W-1:0]    ch_q, ch_n;
  logic [COORD_W:0]   py_q, py_n;
  logic [COORD_W:0]   px_q, px_n;

  logic               valid_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [1:0]         en_q;

  logic [COORD_W:0]   ext_x, ext_y;
  logic               last_x, last_y, last_ch, last_elem;
  logic               accept, empty_cfg, fire;

  logic [CH_W-1:0]    map_ch;
  logic [COORD_W:0]   map_py, map_px;
  logic [ADDR_W-1:0]  map_base;
  logic [COORD_W-1:0] map_fm_x, map_fm_y;
  logic [PAD_W-1:0]   map_pad_u, map_pad_l;
  logic [ADDR_W-1:0]  map_addr;
  logic [1:0]         map_en;

  assign ext_x = {1'b0, fm_x_q} + (COORD_W+1)'(pad_l_q) + (COORD_W+1)'(pad_r_q);
  assign ext_y = {1'b0, fm_y_q} + (COORD_W+1)'(pad_u_q) + (COORD_W+1)'(pad_d_q);

  assign last_x    = (px_q == ext_x - (COORD_W+1)'(1));
  assign last_y    = (py_q == ext_y - (COORD_W+1)'(1));
  assign last_ch   = (ch_q == fm_ch_q - CH_W'(1));
  assign last_elem = last_x && last_y && last_ch;

  assign accept    = (state_q == ST_IDLE) && start;
  assign empty_cfg = (fmX == '0) || (fmY == '0) || (fmCh == '0);
  assign fire      = valid_q && outReady;

  always_comb begin
    ch_n = ch_q;
    py_n = py_q;
    px_n = px_q + (COORD_W+1)'(1);
    if (last_x) begin
      px_n = '0;
      py_n = py_q + (COORD_W+1)'(1);
      if (last_y) begin
        py_n = '0;
        ch_n = ch_q + CH_W'(1);
      end
    end
  end

  // The map looks one element ahead: raw inputs at origin while idle, latched config otherwise.
  always_comb begin
    map_ch    = ch_n;
    map_py    = py_n;
    map_px    = px_n;
    map_base  = base_q;
    map_fm_x  = fm_x_q;
    map_fm_y  = fm_y_q;
    map_pad_u = pad_u_q;
    map_pad_l = pad_l_q;
    if (state_q == ST_IDLE) begin
      map_ch    = '0;
      map_py    = '0;
      map_px    = '0;
      map_base  = baseAddr;
      map_fm_x  = fmX;
      map_fm_y  = fmY;
      map_pad_u = paddingUp;
      map_pad_l = paddingLeft;
    end
  end

  padding_pixel_map #(
    .ADDR_W  (ADDR_W),
    .COORD_W (COORD_W),
    .PAD_W   (PAD_W),
    .CH_W    (CH_W)
  ) u_map (
    .ch       (map_ch),
    .py       (map_py),
    .px       (map_px),
    .base     (map_base),
    .fm_x     (map_fm_x),
    .fm_y     (map_fm_y),
    .pad_up   (map_pad_u),
    .pad_left (map_pad_l),
    .addr     (map_addr),
    .en       (map_en)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = empty_cfg ? ST_DONE : ST_RUN;
      ST_RUN:  if (fire && last_elem) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      fm_x_q  <= '0;
      fm_y_q  <= '0;
      fm_ch_q <= '0;
      pad_u_q <= '0;
      pad_d_q <= '0;
      pad_l_q <= '0;
      pad_r_q <= '0;
      ch_q    <= '0;
      py_q    <= '0;
      px_q    <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      en_q    <= EN_NONE;
    end else begin
      state_q <= state_d;
      if (accept) begin
        base_q  <= baseAddr;
        fm_x_q  <= fmX;
        fm_y_q  <= fmY;
        fm_ch_q <= fmCh;
        pad_u_q <= paddingUp;
        pad_d_q <= paddingDown;
        pad_l_q <= paddingLeft;
        pad_r_q <= paddingRight;
        ch_q    <= '0;
        py_q    <= '0;
        px_q    <= '0;
        if (!empty_cfg) begin
          valid_q <= 1'b1;
          addr_q  <= map_addr;
          en_q    <= map_en;
        end
      end else if ((state_q == ST_RUN) && fire) begin
        if (last_elem) begin
          valid_q <= 1'b0;
          addr_q  <= '0;
          en_q    <= EN_NONE;
        end else begin
          ch_q    <= ch_n;
          py_q    <= py_n;
          px_q    <= px_n;
          valid_q <= 1'b1;
          addr_q  <= map_addr;
          en_q    <= map_en;
        end
      end
    end
  end

  assign outValid   = valid_q;
  assign realAddr   = addr_q;
  assign realAddrEn = en_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_padding_addr_gen.sv
// tb/tb_padding_addr_gen.sv - randomized self-checking bench for padding_addr_gen
module tb_padding_addr_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [63:0] baseAddr = '0;
  logic [10:0] fmX = '0, fmY = '0;
  logic [7:0]  fmCh = '0;
  logic [3:0]  paddingUp = '0, paddingDown = '0, paddingLeft = '0, paddingRight = '0;
  logic        outReady = 1'b0;
  logic        outValid;
  logic [63:0] realAddr;
  logic [1:0]  realAddrEn;
  logic        busy, done;

  int checks = 0;
  int failures = 0;

  logic [63:0] exp_addr[$], obs_addr[$];
  logic [1:0]  exp_en[$], obs_en[$];
  int done_cyc, done_count, first_valid, last_fire, stall_errs, idle_errs, timed_out;

  padding_addr_gen dut (
    .clk(clk), .rst(rst), .start(start), .baseAddr(baseAddr),
    .fmX(fmX), .fmY(fmY), .fmCh(fmCh),
    .paddingUp(paddingUp), .paddingDown(paddingDown),
    .paddingLeft(paddingLeft), .paddingRight(paddingRight),
    .outReady(outReady), .outValid(outValid), .realAddr(realAddr),
    .realAddrEn(realAddrEn), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic set_cfg(input logic [63:0] b, input int x, input int y, input int c,
                         input int u, input int d, input int l, input int r);
    baseAddr = b; fmX = 11'(x); fmY = 11'(y); fmCh = 8'(c);
    paddingUp = 4'(u); paddingDown = 4'(d); paddingLeft = 4'(l); paddingRight = 4'(r);
  endtask

  // Reference: walk the padded grid directly from the configuration.
  task automatic build_expected();
    int x, y, c, u, d, l, r;
    x = fmX; y = fmY; c = fmCh; u = paddingUp; d = paddingDown; l = paddingLeft; r = paddingRight;
    exp_addr.delete(); exp_en.delete();
    if (x == 0 || y == 0 || c == 0) return;
    for (int ch = 0; ch < c; ch++)
      for (int py = 0; py < y + u + d; py++)
        for (int px = 0; px < x + l + r; px++)
          if (px >= l && px < l + x && py >= u && py < u + y) begin
            exp_addr.push_back(baseAddr + 64'((ch * y + (py - u)) * x + (px - l)));
            exp_en.push_back(2'd2);
          end else begin
            exp_addr.push_back(64'd0);
            exp_en.push_back(2'd1);
          end
  endtask

  function automatic int seq_diffs();
    int n = 0;
    if (obs_addr.size() != exp_addr.size()) n++;
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
      if (obs_addr[i] !== exp_addr[i] || obs_en[i] !== exp_en[i]) n++;
    return n;
  endfunction

  task automatic run_sweep(input int ready_pct, input int glitch_cyc, input bit scramble);
    logic        hold_v;
    logic [63:0] h_addr;
    logic [1:0]  h_en;
    obs_addr.delete(); obs_en.delete();
    done_cyc = -1; done_count = 0; first_valid = -1; last_fire = -1;
    stall_errs = 0; idle_errs = 0; timed_out = 1; hold_v = 1'b0; h_addr = '0; h_en = '0;
    @(negedge clk);
    start = 1'b1;
    outReady = ($urandom_range(99) < ready_pct);
    @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      start = (c == glitch_cyc);
      if (scramble && c == 1)
        set_cfg({$urandom, $urandom}, $urandom_range(7), $urandom_range(7), $urandom_range(3),
                $urandom_range(15), $urandom_range(15), $urandom_range(15), $urandom_range(15));
      if (hold_v && (outValid !== 1'b1 || realAddr !== h_addr || realAddrEn !== h_en)) stall_errs++;
      if (outValid !== 1'b1 && (realAddr !== 64'd0 || realAddrEn !== 2'd0)) idle_errs++;
      if (outValid === 1'b1 && first_valid < 0) first_valid = c;
      if (done === 1'b1) begin
        done_count++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_count > 0 && done !== 1'b1 && busy !== 1'b1) begin
        timed_out = 0;
        break;
      end
      outReady = ($urandom_range(99) < ready_pct);
      if (outValid === 1'b1 && outReady) begin
        obs_addr.push_back(realAddr);
        obs_en.push_back(realAddrEn);
        last_fire = c;
        hold_v = 1'b0;
      end else begin
        hold_v = outValid;
        h_addr = realAddr;
        h_en = realAddrEn;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({outValid, done, busy, realAddrEn} !== 5'd0 || realAddr !== 64'd0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b done=%b busy=%b en=%0d addr=%0h, required all 0",
               outValid, done, busy, realAddrEn, realAddr);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_channel();
    set_cfg(64'd4, 5, 5, 1, 2, 2, 2, 2);
    build_expected();
    run_sweep(100, -1, 1'b0);
    checks++;
    if (obs_addr.size() !== 81) begin failures++; $display("FAIL basic_beats: got %0d, required 81", obs_addr.size()); end
    checks++;
    if (timed_out !== 0) begin failures++; $display("FAIL basic_timeout: sweep did not finish, required finish"); end
    checks++;
    if (first_valid !== 0) begin failures++; $display("FAIL basic_first_latency: valid at cycle %0d, required 0", first_valid); end
    checks++;
    if (obs_addr.size() < 81 || obs_en[0] !== 2'd1 || obs_addr[0] !== 64'd0)
      begin failures++; $display("FAIL basic_beat0: first beat wrong or missing, required en=1 addr=0"); end
    checks++;
    if (obs_addr.size() < 81 || obs_addr[21] !== 64'd5 || obs_en[21] !== 2'd2 ||
        obs_addr[38] !== 64'd14 || obs_en[38] !== 2'd2 || obs_addr[49] !== 64'd21 ||
        obs_en[49] !== 2'd2 || obs_en[80] !== 2'd1)
      begin failures++; $display("FAIL basic_points: sampled beats (21,38,49,80) wrong, required 5/14/21 en2 and en1"); end
    checks++;
    if (done_cyc !== last_fire + 1 || done_count !== 1)
      begin failures++; $display("FAIL basic_done: done at %0d x%0d, required at %0d x1", done_cyc, done_count, last_fire + 1); end
    checks++;
    if (seq_diffs() !== 0) begin failures++; $display("FAIL basic_sequence: %0d differences, required 0", seq_diffs()); end
  endtask

  task automatic test_two_channels();
    set_cfg(64'd4, 5, 5, 2, 2, 2, 2, 2);
    build_expected();
    run_sweep(100, -1, 1'b0);
    checks++;
    if (obs_addr.size() !== 162) begin failures++; $display("FAIL ch2_beats: got %0d, required 162", obs_addr.size()); end
    checks++;
    if (obs_addr.size() < 162 || obs_en[81] !== 2'd1 || obs_addr[101] !== 64'd29 || obs_en[101] !== 2'd2)
      begin failures++; $display("FAIL ch2_points: beat 81/101 wrong, required en1 and addr 29 en2"); end
    checks++;
    if (seq_diffs() !== 0) begin failures++; $display("FAIL ch2_sequence: %0d differences, required 0", seq_diffs()); end
  endtask

  task automatic test_backpressure();
    set_cfg(64'd4, 5, 5, 1, 2, 2, 2, 2);
    build_expected();
    run_sweep(50, -1, 1'b0);
    checks++;
    if (seq_diffs() !== 0) begin failures++; $display("FAIL bp_sequence: %0d differences, required 0", seq_diffs()); end
    checks++;
    if (stall_errs !== 0) begin failures++; $display("FAIL bp_stall_hold: %0d unstable stall cycles, required 0", stall_errs); end
    checks++;
    if (idle_errs !== 0) begin failures++; $display("FAIL bp_idle_zero: %0d nonzero idle cycles, required 0", idle_errs); end
    checks++;
    if (done_cyc !== last_fire + 1) begin failures++; $display("FAIL bp_done: done at %0d, required %0d", done_cyc, last_fire + 1); end
  endtask

  task automatic test_random_cfg();
    for (int t = 0; t < 6; t++) begin
      set_cfg((t == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : {$urandom, $urandom},
              $urandom_range(6), 1 + $urandom_range(4), 1 + $urandom_range(2),
              $urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(3));
      build_expected();
      run_sweep(70, -1, 1'b1);
      checks++;
      if (seq_diffs() !== 0 || stall_errs !== 0 || idle_errs !== 0 || timed_out !== 0)
        begin failures++; $display("FAIL rand_cfg_%0d: diffs=%0d stall=%0d idle=%0d timeout=%0d, required all 0", t, seq_diffs(), stall_errs, idle_errs, timed_out); end
      checks++;
      if (done_cyc !== ((exp_addr.size() == 0) ? 0 : last_fire + 1) || done_count !== 1)
        begin failures++; $display("FAIL rand_done_%0d: done at %0d x%0d, required single pulse after last beat", t, done_cyc, done_count); end
    end
  endtask

  task automatic test_empty_and_restart();
    set_cfg(64'd100, 5, 0, 1, 1, 1, 1, 1);
    run_sweep(100, -1, 1'b0);
    checks++;
    if (obs_addr.size() !== 0 || first_valid !== -1)
      begin failures++; $display("FAIL empty_beats: got %0d beats, required 0", obs_addr.size()); end
    checks++;
    if (done_cyc !== 0 || done_count !== 1)
      begin failures++; $display("FAIL empty_done: done at %0d x%0d, required at 0 x1", done_cyc, done_count); end
    set_cfg(64'd4, 5, 5, 1, 2, 2, 2, 2);
    build_expected();
    run_sweep(100, 10, 1'b0);
    checks++;
    if (seq_diffs() !== 0 || done_count !== 1)
      begin failures++; $display("FAIL start_in_run: %0d differences, %0d done pulses, required 0 and 1", seq_diffs(), done_count); end
  endtask

  task automatic test_reset_mid();
    int fires = 0;
    int seen = 0;
    set_cfg(64'd4, 5, 5, 1, 2, 2, 2, 2);
    @(negedge clk);
    start = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (c > 0) @(negedge clk);
      if (outValid === 1'b1 && fires == 40) seen = 1;
      else if (outValid === 1'b1) fires++;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL rst_mid_reach: beat 40 not reached, required reached"); end
    rst = 1'b1;
    #1;
    checks++;
    if ({outValid, done, busy, realAddrEn} !== 5'd0 || realAddr !== 64'd0)
      begin failures++; $display("FAIL rst_mid_outputs: valid=%b done=%b busy=%b en=%0d addr=%0h, required all 0", outValid, done, busy, realAddrEn, realAddr); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (outValid !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL rst_mid_quiet: %0d active cycles after release, required 0", seen); end
    build_expected();
    run_sweep(100, -1, 1'b0);
    checks++;
    if (seq_diffs() !== 0 || obs_addr.size() < 1 || obs_en[0] !== 2'd1)
      begin failures++; $display("FAIL rst_mid_restart: %0d differences, required 0 from beat 0", seq_diffs()); end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_two_channels();
    test_backpressure();
    test_random_cfg();
    test_empty_and_restart();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
